mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the pipelined MIPS core. Sits in the E stage. Accepts mult/multu/div/divu/mthi/mtlo from the E-stage instruction and owns the HI/LO registers. Models multi-cycle execution latency with a busy counter and raises a stall request that freezes D and bubbles E while any D-stage multiply/divide-class instruction would conflict.

---
 rtl/mdu_ctrl.sv | 128 ++++++++++++
 tb/tb_mdu_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: owns HI/LO, models multi-cycle
// latency with a busy counter and requests a D-stage stall on conflicts.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [2:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md_uses,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [3:0] MULT_LD  = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD   = 4'(DIV_CYCLES);

  logic        r_busy;
  logic [3:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_sh_hi;
  logic [31:0] r_sh_lo;
  logic        r_skip;

  logic        w_is_md;
  logic        w_is_div;
  logic        w_start;
  logic        w_done;
  logic [63:0] w_result;

  function automatic logic [63:0] mul_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (sgn) p = 64'(sa * sb);
    else     p = {32'd0, a} * {32'd0, b};
    return p;
  endfunction

  // Returns {remainder, quotient}; zero divisor yields 0 (never committed).
  function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        q;
    logic [31:0]        r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign w_is_md  = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU) ||
                    (e_md_op == OP_DIV)  || (e_md_op == OP_DIVU);
  assign w_is_div = (e_md_op == OP_DIV) || (e_md_op == OP_DIVU);
  assign w_start  = e_valid && w_is_md && !r_busy;
  assign w_done   = r_busy && (r_count == 4'd1);
  assign w_result = w_is_div ? div_res(e_rs, e_rt, e_md_op == OP_DIV)
                             : mul_res(e_rs, e_rt, e_md_op == OP_MULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_count <= 4'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_sh_hi <= 32'd0;
      r_sh_lo <= 32'd0;
      r_skip  <= 1'b0;
    end else if (w_start) begin
      r_sh_hi <= w_result[63:32];
      r_sh_lo <= w_result[31:0];
      r_count <= w_is_div ? DIV_LD : MULT_LD;
      r_busy  <= 1'b1;
      r_skip  <= w_is_div && (e_rt == 32'd0);
    end else if (r_busy) begin
      if (w_done) begin
        r_busy  <= 1'b0;
        r_count <= 4'd0;
        if (!r_skip) begin
          r_hi <= r_sh_hi;
          r_lo <= r_sh_lo;
        end
      end else begin
        r_count <= r_count - 4'd1;
      end
    end else if (e_valid) begin
      // Moves to HI/LO only land when no operation is in flight.
      if (e_md_op == OP_MTHI)      r_hi <= e_rs;
      else if (e_md_op == OP_MTLO) r_lo <= e_rs;
    end
  end

  assign stall = d_md_uses && (r_busy || w_start);
  assign busy  = r_busy;
  assign done  = w_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO/latency pushed at issue,
// checked by a monitor whenever an operation finishes.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [2:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_md_uses;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    int          dones;
  } exp_t;

  exp_t sb[$];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
    .e_rs(e_rs), .e_rt(e_rt), .d_md_uses(d_md_uses), .stall(stall),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: counts busy/done cycles and checks HI/LO when busy falls.
  initial begin
    int   bcnt;
    int   dcnt;
    logic prev_busy;
    exp_t e;
    bcnt = 0;
    dcnt = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        bcnt++;
        if (done === 1'b1) dcnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_busy_len"}, 32'(bcnt), 32'(e.len));
          chk({e.name, "_done_cnt"}, 32'(dcnt), 32'(e.dones));
        end
        bcnt = 0;
        dcnt = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b0) break;
      tick();
    end
    if (busy !== 1'b0) chk({nm, "_timeout"}, 32'd1, 32'd0);
    tick();
  endtask

  task automatic push(input string nm, input logic [31:0] h, input logic [31:0] l,
                      input int len, input int dn);
    exp_t e;
    e.name = nm; e.hi = h; e.lo = l; e.len = len; e.dones = dn;
    sb.push_back(e);
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] h, input logic [31:0] l,
                        input int len);
    push(nm, h, l, len, 1);
    e_valid = 1'b1; e_md_op = op; e_rs = rs; e_rt = rt;
    tick();
    e_valid = 1'b0; e_md_op = 3'd0;
    wait_idle(nm);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    e_valid = 1'b1; e_md_op = op; e_rs = v;
    tick();
    e_valid = 1'b0; e_md_op = 3'd0;
  endtask

  initial begin
    int n;
    e_valid = 1'b0; e_md_op = 3'd0; e_rs = 32'd0; e_rt = 32'd0; d_md_uses = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    run_op("mult",  3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("divu",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 10);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);

    mt(3'd6, 32'h1234);
    chk("mtlo", lo, 32'h1234);
    mt(3'd5, 32'h5678);
    chk("mthi", hi, 32'h5678);
    run_op("divu_zero", 3'd4, 32'hABCD, 32'd0, 32'h5678, 32'h1234, 10);

    // mflo in D alongside a mult start: stall for start cycle + 5 busy cycles.
    push("mult_stall", 32'd0, 32'd12, 5, 1);
    e_valid = 1'b1; e_md_op = 3'd1; e_rs = 32'd3; e_rt = 32'd4; d_md_uses = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (stall !== 1'b1) break;
      n++;
      @(posedge clk); #1;
      e_valid = 1'b0; e_md_op = 3'd0;
    end
    chk("stall_cycles", 32'(n), 32'd6);
    chk("mflo_after_stall", lo, 32'd12);
    d_md_uses = 1'b0;
    tick();
    wait_idle("mult_stall");

    push("mult_nostall", 32'd0, 32'd1, 5, 1);
    e_valid = 1'b1; e_md_op = 3'd1; e_rs = 32'hFFFF_FFFF; e_rt = 32'hFFFF_FFFF;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (stall !== 1'b0) n++;
      @(posedge clk); #1;
      e_valid = 1'b0; e_md_op = 3'd0;
    end
    chk("nostall_cycles", 32'(n), 32'd0);
    wait_idle("mult_nostall");

    // mthi during busy is dropped; the multu result then commits.
    push("mthi_busy", 32'd1, 32'd0, 5, 1);
    e_valid = 1'b1; e_md_op = 3'd2; e_rs = 32'h0001_0000; e_rt = 32'h0001_0000;
    tick();
    e_valid = 1'b0; e_md_op = 3'd0;
    tick();
    mt(3'd5, 32'hDEAD);
    chk("mthi_ignored", hi, 32'd0);
    wait_idle("mthi_busy");

    // Reset in the 4th busy cycle of a div aborts it without commit.
    push("div_reset", 32'd0, 32'd0, 4, 0);
    e_valid = 1'b1; e_md_op = 3'd3; e_rs = 32'd100; e_rt = 32'd7;
    tick();
    e_valid = 1'b0; e_md_op = 3'd0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (12) tick();
    chk("abort_no_commit_hi", hi, 32'd0);
    chk("abort_no_commit_lo", lo, 32'd0);
    chk("abort_busy_late", 32'(busy), 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
